seg7_scan_pwm_driver: RTL and testbench

- Time-multiplexed 4-digit seven-segment display driver with PWM brightness, anti-ghost blanking and tear-free input snapshotting.
- Sits directly downstream of the wall-clock time counters. It consumes four BCD digits (hours2, hours1, mins2, mins1) and an 8-bit brightness from switches.
- Drives the board's anode enables and cathode lines; all outputs are registered.

---
 rtl/seg7_scan_pwm_driver.sv | 221 ++++++++++++++++++++++
 tb/tb_seg7_scan_pwm_driver.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_pwm_driver.sv
// seg7_scan_pwm_driver
// Time-multiplexed 4-digit seven-segment driver with PWM brightness,
// anti-ghost blanking at the start of every digit slot and a per-frame
// snapshot of the digit inputs so a frame never mixes two input values.
//
// Ports:
//   CLK100MHZ       system clock, rising edge
//   Reset           asynchronous, active-high reset
//   bcd3..bcd0      BCD digits, bcd3 leftmost (hours2) .. bcd0 rightmost (mins1)
//   dp_mask         decimal point enable, bit i -> digit i
//   blank_lz        blank digit 3 when its snapshot value is 0
//   pwm_in          brightness duty, 0 = off, 255 = 255/256 on
//   SegmentDrivers  anode enables, active-low, bit i = digit i, bits 7:4 = 1
//   SevenSegment    cathodes {dp,g,f,e,d,c,b,a}, active-low
module seg7_scan_pwm_driver #(
  parameter int REFRESH_DIV = 100000,
  parameter int BLANK       = 500
) (
  input  logic       CLK100MHZ,
  input  logic       Reset,
  input  logic [3:0] bcd3,
  input  logic [3:0] bcd2,
  input  logic [3:0] bcd1,
  input  logic [3:0] bcd0,
  input  logic [3:0] dp_mask,
  input  logic       blank_lz,
  input  logic [7:0] pwm_in,
  output logic [7:0] SegmentDrivers,
  output logic [7:0] SevenSegment
);

  localparam int CW = $clog2(REFRESH_DIV);

  typedef enum logic [1:0] {
    DIG0 = 2'd0,
    DIG1 = 2'd1,
    DIG2 = 2'd2,
    DIG3 = 2'd3
  } scan_state_t;

  scan_state_t state_r, state_next_s;
  logic [CW-1:0] slot_cnt_r;
  logic          slot_last_s;
  logic [7:0]    pwm_cnt_r;
  logic [7:0]    duty_r;
  logic          pwm_on_s;
  logic          first_cycle_r;
  logic          capture_s;
  logic [15:0]   snap_digits_r;
  logic [3:0]    snap_dp_r;
  logic          snap_lz_r;
  logic [15:0]   cur_digits_s;
  logic [3:0]    cur_dp_s;
  logic          cur_lz_s;
  logic [3:0]    digit_val_s;
  logic          dp_bit_s;
  logic [3:0]    anode_sel_s;
  logic          digit_blank_s;
  logic          anode_on_s;
  logic [7:0]    anode_next_s;
  logic [7:0]    cathode_next_s;

  // BCD to active-low {g,f,e,d,c,b,a}; non-decimal codes are dark
  function automatic logic [6:0] seg7_encode(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  assign slot_last_s = (slot_cnt_r == CW'(REFRESH_DIV - 1));
  assign pwm_on_s    = (pwm_cnt_r < duty_r);
  // Capture at DIG0 entry, and on the very first cycle after reset
  assign capture_s   = first_cycle_r | ((state_r == DIG3) & slot_last_s);

  // Scan state register and slot counter
  always_ff @(posedge CLK100MHZ or posedge Reset) begin
    if (Reset) begin
      state_r    <= DIG0;
      slot_cnt_r <= '0;
    end else begin
      state_r    <= state_next_s;
      slot_cnt_r <= slot_last_s ? '0 : slot_cnt_r + {{(CW-1){1'b0}}, 1'b1};
    end
  end

  // Next-state: advance one digit at the end of each slot
  always_comb begin
    state_next_s = state_r;
    if (slot_last_s) begin
      case (state_r)
        DIG0:    state_next_s = DIG1;
        DIG1:    state_next_s = DIG2;
        DIG2:    state_next_s = DIG3;
        DIG3:    state_next_s = DIG0;
        default: state_next_s = DIG0;
      endcase
    end else begin
      state_next_s = state_r;
    end
  end

  // Free-running PWM counter; duty only reloads on wrap to avoid partial periods
  always_ff @(posedge CLK100MHZ or posedge Reset) begin
    if (Reset) begin
      pwm_cnt_r <= 8'd0;
      duty_r    <= 8'd0;
    end else begin
      pwm_cnt_r <= pwm_cnt_r + 8'd1;
      if (pwm_cnt_r == 8'd255) begin
        duty_r <= pwm_in;
      end
    end
  end

  // Frame snapshot of the display inputs
  always_ff @(posedge CLK100MHZ or posedge Reset) begin
    if (Reset) begin
      first_cycle_r <= 1'b1;
      snap_digits_r <= 16'd0;
      snap_dp_r     <= 4'd0;
      snap_lz_r     <= 1'b0;
    end else begin
      first_cycle_r <= 1'b0;
      if (capture_s) begin
        snap_digits_r <= {bcd3, bcd2, bcd1, bcd0};
        snap_dp_r     <= dp_mask;
        snap_lz_r     <= blank_lz;
      end
    end
  end

  // On the first cycle the snapshot is still being loaded, so read the inputs
  // directly; otherwise the cathodes would change again one cycle later, which
  // with BLANK=1 would coincide with the anode turning on.
  always_comb begin
    cur_digits_s = snap_digits_r;
    cur_dp_s     = snap_dp_r;
    cur_lz_s     = snap_lz_r;
    if (first_cycle_r) begin
      cur_digits_s = {bcd3, bcd2, bcd1, bcd0};
      cur_dp_s     = dp_mask;
      cur_lz_s     = blank_lz;
    end else begin
      cur_digits_s = snap_digits_r;
      cur_dp_s     = snap_dp_r;
      cur_lz_s     = snap_lz_r;
    end
  end

  // Select the active digit and compute the next anode/cathode values
  always_comb begin
    digit_val_s = 4'd0;
    dp_bit_s    = 1'b0;
    anode_sel_s = 4'b0000;
    case (state_r)
      DIG0: begin
        digit_val_s = cur_digits_s[3:0];
        dp_bit_s    = cur_dp_s[0];
        anode_sel_s = 4'b0001;
      end
      DIG1: begin
        digit_val_s = cur_digits_s[7:4];
        dp_bit_s    = cur_dp_s[1];
        anode_sel_s = 4'b0010;
      end
      DIG2: begin
        digit_val_s = cur_digits_s[11:8];
        dp_bit_s    = cur_dp_s[2];
        anode_sel_s = 4'b0100;
      end
      DIG3: begin
        digit_val_s = cur_digits_s[15:12];
        dp_bit_s    = cur_dp_s[3];
        anode_sel_s = 4'b1000;
      end
      default: begin
        digit_val_s = 4'd0;
        dp_bit_s    = 1'b0;
        anode_sel_s = 4'b0000;
      end
    endcase
    digit_blank_s = (state_r == DIG3) & cur_lz_s & (digit_val_s == 4'd0);
    anode_on_s    = (slot_cnt_r >= CW'(BLANK)) & pwm_on_s & ~digit_blank_s;
    if (anode_on_s) begin
      anode_next_s = {4'hF, ~anode_sel_s};
    end else begin
      anode_next_s = 8'hFF;
    end
    // Cathodes depend only on the snapshot and digit, so they are constant
    // within a slot and only move on slot entry while the anodes are blanked.
    if (digit_blank_s || (digit_val_s > 4'd9)) begin
      cathode_next_s = 8'hFF;
    end else begin
      cathode_next_s = {~dp_bit_s, seg7_encode(digit_val_s)};
    end
  end

  // Registered outputs
  always_ff @(posedge CLK100MHZ or posedge Reset) begin
    if (Reset) begin
      SegmentDrivers <= 8'hFF;
      SevenSegment   <= 8'hFF;
    end else begin
      SegmentDrivers <= anode_next_s;
      SevenSegment   <= cathode_next_s;
    end
  end

endmodule

// File: tb/tb_seg7_scan_pwm_driver.sv
// Bench for seg7_scan_pwm_driver with REFRESH_DIV=16, BLANK=2.
// The reference model derives outputs from elapsed cycles since reset release
// (slot, digit, PWM phase) and from a per-edge history of the inputs.
module tb_seg7_scan_pwm_driver;
  localparam int RD    = 16;
  localparam int BL    = 2;
  localparam int FRAME = 4 * RD;
  localparam int HMAX  = 4096;

  logic       clk = 1'b0;
  logic       Reset;
  logic [3:0] bcd3, bcd2, bcd1, bcd0, dp_mask;
  logic       blank_lz;
  logic [7:0] pwm_in;
  logic [7:0] SegmentDrivers, SevenSegment;

  seg7_scan_pwm_driver #(.REFRESH_DIV(RD), .BLANK(BL)) dut (
    .CLK100MHZ(clk), .Reset(Reset), .bcd3(bcd3), .bcd2(bcd2), .bcd1(bcd1),
    .bcd0(bcd0), .dp_mask(dp_mask), .blank_lz(blank_lz), .pwm_in(pwm_in),
    .SegmentDrivers(SegmentDrivers), .SevenSegment(SevenSegment)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int n     = 0;
  bit in_rst = 1'b1;
  bit cnt_en = 1'b0;
  int low_cnt = 0;
  logic [7:0] prev_ss = 8'hFF;
  logic [15:0] h_bcd [HMAX];
  logic [3:0]  h_dp  [HMAX];
  logic        h_lz  [HMAX];
  logic [7:0]  h_pwm [HMAX];
  logic [7:0]  tbl [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                            8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s n=%0d observed=%h expected=%h", tag, n, obs, exp);
    end
  endtask

  task automatic check_model(input int k);
    int d, s, pc, se, duty;
    logic [15:0] b;
    logic [3:0] val;
    logic blanked, on;
    logic [7:0] exp_sd, exp_ss;
    d  = (k / RD) % 4;
    s  = k % RD;
    pc = k % 256;
    se = (k < FRAME) ? 1 : FRAME * (k / FRAME);
    b  = h_bcd[se];
    val = b[d*4 +: 4];
    duty = (k < 256) ? 0 : int'(h_pwm[256 * (k / 256)]);
    blanked = (d == 3) && h_lz[se] && (val == 4'd0);
    on = (s >= BL) && (pc < duty) && !blanked;
    exp_sd = on ? ~(8'h01 << d) : 8'hFF;
    if (blanked || val > 4'd9) exp_ss = 8'hFF;
    else exp_ss = tbl[val] & ~{h_dp[se][d], 7'b0};
    check("anodes", SegmentDrivers, exp_sd);
    check("cathodes", SevenSegment, exp_ss);
  endtask

  task automatic tick();
    @(posedge clk);
    if (!in_rst) begin
      n++;
      if (n >= HMAX) begin
        $display("FAIL history overflow n=%0d", n);
        $fatal(1);
      end
      h_bcd[n] = {bcd3, bcd2, bcd1, bcd0};
      h_dp[n]  = dp_mask;
      h_lz[n]  = blank_lz;
      h_pwm[n] = pwm_in;
    end
    #1;
    if (in_rst) begin
      check("rst_anodes", SegmentDrivers, 8'hFF);
      check("rst_cathodes", SevenSegment, 8'hFF);
    end else begin
      check_model(n - 1);
    end
    total++;
    assert ($countones(~SegmentDrivers) <= 1) else begin
      bad++;
      $error("FAIL one_hot observed=%h expected=at_most_one_low", SegmentDrivers);
    end
    if (SevenSegment !== prev_ss) begin
      total++;
      assert (SegmentDrivers === 8'hFF) else begin
        bad++;
        $error("FAIL ghost observed=%h expected=ff (cathode change %h->%h)",
               SegmentDrivers, prev_ss, SevenSegment);
      end
    end
    if (cnt_en && SegmentDrivers !== 8'hFF) low_cnt++;
    prev_ss = SevenSegment;
  endtask

  initial begin
    Reset = 1'b1; in_rst = 1'b1;
    {bcd3, bcd2, bcd1, bcd0} = {4'd1, 4'd2, 4'd3, 4'd4};
    dp_mask = 4'd0; blank_lz = 1'b0; pwm_in = 8'd255;
    // Test 1: reset held, then released; scan with full brightness
    for (int i = 0; i < 5; i++) tick();
    Reset = 1'b0; in_rst = 1'b0; n = 0;
    for (int i = 0; i < 400; i++) tick();
    // Test 2: zero duty keeps anodes dark, then a quarter duty
    pwm_in = 8'd0;
    for (int i = 0; i < 700; i++) tick();
    pwm_in = 8'd64;
    for (int i = 0; i < 300 && ((n - 1) % 256) != 255; i++) tick();
    low_cnt = 0; cnt_en = 1'b1;
    for (int i = 0; i < 256; i++) tick();
    cnt_en = 1'b0;
    // 64 on-phase cycles cover 4 slot starts, each losing BLANK cycles
    check("pwm64_window", 8'(low_cnt), 8'(64 - 4 * BL));
    // Test 3: change bcd0 while DIG2 is displayed
    pwm_in = 8'd255;
    for (int i = 0; i < 300 && (((n - 1) / RD) % 4) != 2; i++) tick();
    bcd0 = 4'd7;
    for (int i = 0; i < 2 * FRAME; i++) tick();
    // Test 4: leading zero blank, invalid code, decimal point
    bcd3 = 4'd0; blank_lz = 1'b1; bcd1 = 4'd12; dp_mask = 4'b0100; bcd2 = 4'd2;
    for (int i = 0; i < 200; i++) tick();
    // Randomized inputs
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        case ($urandom_range(0, 6))
          0: bcd0 = 4'($urandom_range(0, 15));
          1: bcd1 = 4'($urandom_range(0, 15));
          2: bcd2 = 4'($urandom_range(0, 15));
          3: bcd3 = 4'($urandom_range(0, 15));
          4: dp_mask = 4'($urandom);
          5: blank_lz = 1'($urandom);
          default: pwm_in = 8'($urandom);
        endcase
      end
      tick();
    end
    // Test 5: asynchronous reset in the middle of DIG2
    for (int i = 0; i < 300 && !(((n - 1) / RD) % 4 == 2 && (n - 1) % RD == 6); i++) tick();
    #2; Reset = 1'b1; #1;
    check("async_anodes", SegmentDrivers, 8'hFF);
    check("async_cathodes", SevenSegment, 8'hFF);
    prev_ss = SevenSegment;
    in_rst = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    {bcd3, bcd2, bcd1, bcd0} = {4'd9, 4'd8, 4'd7, 4'd6};
    dp_mask = 4'($urandom); blank_lz = 1'b0; pwm_in = 8'd200;
    Reset = 1'b0; in_rst = 1'b0; n = 0;
    for (int i = 0; i < 400; i++) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
